// File: rtl/rc5_key_expand_pkg.sv
// rc5_pkg: shared RC5-16 constants, types and helpers
// for the key schedule and the encrypt/decrypt core.
package rc5_pkg;

   localparam int          W          = 16;
   localparam logic [15:0] P16        = 16'hB7E1;
   localparam logic [15:0] Q16        = 16'h9E37;
   localparam int          MAX_ROUNDS = 31;
   localparam int          T_MAX      = 2 * (MAX_ROUNDS + 1);
   localparam int          C_WORDS    = 8;

   typedef logic [W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      MIX
   } ks_state_t;

   function automatic word_t rotl16(word_t x, logic [3:0] s);
      logic [31:0] d;
      d = {x, x} << s;
      return d[31:16];
   endfunction

endpackage

// File: rtl/rc5_key_expand_if.sv
// rc5_key_expand_if: control, key load and subkey
// read bus between the key schedule and its user.
interface rc5_key_expand_if;
   import rc5_pkg::*;

   logic         start;
   logic [4:0]   num_rounds;
   logic [127:0] key;
   logic         busy;
   logic         ready;
   logic         err;
   logic [5:0]   sk_addr;
   word_t        sk_data;

   modport master (
      output start, num_rounds, key, sk_addr,
      input  busy, ready, err, sk_data
   );

   modport slave (
      input  start, num_rounds, key, sk_addr,
      output busy, ready, err, sk_data
   );

endinterface

// File: rtl/rc5_key_expand_mix.sv
// rc5_ks_mix: one combinational RC5 key-mixing step,
// producing the new A and B from S[i], L[j], A, B.
module rc5_ks_mix
   import rc5_pkg::*;
(
   input  word_t s_i,
   input  word_t l_i,
   input  word_t a_i,
   input  word_t b_i,
   output word_t a_o,
   output word_t b_o
);

   word_t a_sum;
   word_t ab;
   word_t b_sum;

   // A' = (S+A+B)<<<3, B' = (L+A'+B)<<<(A'+B)
   always_comb begin
      a_sum = s_i + a_i + b_i;
      a_o   = rotl16(a_sum, 4'd3);
      ab    = a_o + b_i;
      b_sum = l_i + ab;
      b_o   = rotl16(b_sum, ab[3:0]);
   end

endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-16 key schedule; expands K into S[]
// once per key load and serves S[] on a registered port.
module rc5_key_expand #(
   parameter int MAX_ROUNDS = 31
) (
   input logic             clk,
   input logic             rst,
   rc5_key_expand_if.slave bus
);
   import rc5_pkg::*;

   localparam int         TM   = 2 * (MAX_ROUNDS + 1);
   localparam logic [5:0] MAXR = 6'(MAX_ROUNDS);

   ks_state_t  state_q, state_d;
   word_t      s_q [TM];
   word_t      l_q [C_WORDS];
   word_t      a_q, b_q;
   word_t      a_mix, b_mix;
   word_t      init_w;
   word_t      rd_q;
   logic [6:0] t_q, t_new;
   logic [7:0] n_q, n_new;
   logic [7:0] cnt_q;
   logic [5:0] i_q;
   logic [2:0] j_q;
   logic       busy_q, ready_q, err_q;
   logic       accept, reject;
   logic       init_last, mix_last;

   assign t_new = {1'b0, bus.num_rounds, 1'b0} + 7'd2;
   assign n_new = (t_new < 7'd8) ? 8'd24
                : {t_new, 1'b0} + {1'b0, t_new};

   assign init_last = (cnt_q == {1'b0, t_q - 7'd1});
   assign mix_last  = (cnt_q == n_q - 8'd1);

   assign init_w = (cnt_q == 8'd0) ? P16
                 : s_q[cnt_q[5:0] - 6'd1] + Q16;

   rc5_ks_mix u_mix (
      .s_i (s_q[i_q]),
      .l_i (l_q[j_q]),
      .a_i (a_q),
      .b_i (b_q),
      .a_o (a_mix),
      .b_o (b_mix)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next state and start accept/reject decode
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if ({1'b0, bus.num_rounds} > MAXR) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = INIT;
               end
            end
         end
         INIT: if (init_last) state_d = MIX;
         MIX:  if (mix_last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // key latch, S[] fill and mixing datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TM; k++) s_q[k] <= '0;
         for (int m = 0; m < C_WORDS; m++) l_q[m] <= '0;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         t_q     <= '0;
         n_q     <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= reject;
         if (accept) begin
            t_q <= t_new;
            n_q <= n_new;
            for (int m = 0; m < C_WORDS; m++)
               l_q[m] <= bus.key[16*m +: 16];
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
         end else if (state_q == INIT) begin
            s_q[cnt_q[5:0]] <= init_w;
            cnt_q <= init_last ? 8'd0 : cnt_q + 8'd1;
         end else if (state_q == MIX) begin
            s_q[i_q] <= a_mix;
            l_q[j_q] <= b_mix;
            a_q      <= a_mix;
            b_q      <= b_mix;
            i_q <= ({1'b0, i_q} + 7'd1 == t_q) ? 6'd0
                 : i_q + 6'd1;
            j_q   <= j_q + 3'd1;
            cnt_q <= cnt_q + 8'd1;
            if (mix_last) begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   // registered subkey read, zero beyond the live table
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q <= '0;
      end else if ({1'b0, bus.sk_addr} < t_q) begin
         rd_q <= s_q[bus.sk_addr];
      end else begin
         rd_q <= '0;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.ready   = ready_q;
   assign bus.err     = err_q;
   assign bus.sk_data = rd_q;

endmodule

// File: tb/tb_rc5_key_expand.sv
// tb_rc5_key_expand: directed runs of the RC5-16 key
// schedule checked against a plain-arithmetic model.
module tb_rc5_key_expand;

   logic clk;
   logic rst_n;

   rc5_key_expand_if bus ();
   rc5_key_expand_if b20 ();

   rc5_key_expand dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   rc5_key_expand #(.MAX_ROUNDS(20)) dut20 (
      .clk (clk),
      .rst (rst_n),
      .bus (b20)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_s [64];
   int          exp_t;
   logic        model_ok;
   logic [5:0]  addr_last;
   logic        rdy_last;
   logic [15:0] e_cmp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rot(input logic [15:0] x,
                                       input int s);
      int sh;
      sh = s % 16;
      if (sh == 0) return x;
      return (x << sh) | (x >> (16 - sh));
   endfunction

   // RC5 key schedule straight from its definition
   function automatic void model(input logic [127:0] k,
                                 input int r);
      logic [15:0] L [8];
      logic [15:0] A, B;
      int t, n, i, j;
      t = 2 * (r + 1);
      n = 3 * ((t > 8) ? t : 8);
      for (int m = 0; m < 64; m++) exp_s[m] = 16'h0;
      exp_s[0] = 16'hB7E1;
      for (int m = 1; m < t; m++)
         exp_s[m] = exp_s[m-1] + 16'h9E37;
      for (int m = 0; m < 8; m++) L[m] = k[16*m +: 16];
      A = 0; B = 0; i = 0; j = 0;
      for (int it = 0; it < n; it++) begin
         A = rot(exp_s[i] + A + B, 3);
         exp_s[i] = A;
         B = rot(L[j] + A + B, int'(A + B) % 16);
         L[j] = B;
         i = (i + 1) % t;
         j = (j + 1) % 8;
      end
      exp_t = t;
   endfunction

   always @(posedge clk) begin
      addr_last <= bus.sk_addr;
      rdy_last  <= bus.ready;
   end

   // sk_data versus model whenever a finished schedule is held
   always @(negedge clk) begin
      if (model_ok && rdy_last && bus.ready) begin
         if (int'(addr_last) < exp_t) e_cmp = exp_s[addr_last];
         else                         e_cmp = 16'h0;
         chk("sk_data_vs_model", bus.sk_data, e_cmp);
      end
   end

   task automatic run(input logic [127:0] k, input logic [4:0] r,
                      input int exp_cyc, input int kick,
                      input logic peek);
      int cyc;
      model_ok = 1'b0;
      model(k, int'(r));
      @(negedge clk);
      bus.sk_addr    = 6'd0;
      bus.key        = k;
      bus.num_rounds = r;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ready_drop_E0", bus.ready, 1'b0);
      cyc = 0;
      while (bus.ready !== 1'b1 && cyc < 400) begin
         if (bus.busy) cyc++;
         if (peek && cyc == 3) chk("S0_init", bus.sk_data, 16'hB7E1);
         if (peek && cyc == 5) chk("S0_mix1", bus.sk_data, 16'hBF0D);
         if (cyc == kick) begin
            bus.start = 1'b1;
            bus.key   = ~k;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.key   = k;
      chk("busy_cycles", cyc, exp_cyc);
      chk("busy_end", bus.busy, 1'b0);
      chk("ready_end", bus.ready, 1'b1);
      model_ok = 1'b1;
   endtask

   task automatic sweep();
      for (int a = 0; a < 64; a++) begin
         bus.sk_addr = 6'(a);
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      int errs, bsy, rdrop, rdy;
      model_ok       = 1'b0;
      bus.start      = 1'b0;
      bus.num_rounds = 5'd0;
      bus.key        = '0;
      bus.sk_addr    = 6'd0;
      b20.start      = 1'b0;
      b20.num_rounds = 5'd0;
      b20.key        = '0;
      b20.sk_addr    = 6'd0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ready", bus.ready, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_sk_data", bus.sk_data, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run(128'h0, 5'd16, 136, 10, 1'b0);
      sweep();
      run(128'h00112233445566778899AABBCCDDEEFF,
          5'd16, 136, -1, 1'b0);
      sweep();
      run(128'h0F0E0D0C0B0A09080706050403020100,
          5'd0, 26, -1, 1'b1);
      sweep();
      run(128'hDEADBEEF_0BADF00D_CAFEBABE_12345678,
          5'd31, 256, -1, 1'b0);
      sweep();

      model_ok = 1'b0;
      @(negedge clk);
      bus.num_rounds = 5'd16;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (50) @(negedge clk);
      chk("busy_mid_mix", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_ready", bus.ready, 1'b0);
      chk("arst_sk_data", bus.sk_data, 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      bus.sk_addr = 6'd0;
      rdy = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.ready || bus.busy) rdy++;
      end
      chk("post_rst_idle", rdy, 0);
      chk("post_rst_s0", bus.sk_data, 16'h0);

      b20.key        = 128'h1;
      b20.num_rounds = 5'd20;
      b20.start      = 1'b1;
      @(negedge clk);
      b20.start = 1'b0;
      rdy = 0;
      while (b20.ready !== 1'b1 && rdy < 400) begin
         if (b20.busy) rdy++;
         @(negedge clk);
      end
      chk("m20_busy_cycles", rdy, 168);
      b20.num_rounds = 5'd21;
      b20.start      = 1'b1;
      @(negedge clk);
      b20.start = 1'b0;
      errs = 0; bsy = 0; rdrop = 0;
      for (int c = 0; c < 6; c++) begin
         if (b20.err)    errs++;
         if (b20.busy)   bsy++;
         if (!b20.ready) rdrop++;
         @(negedge clk);
      end
      chk("m20_err_pulses", errs, 1);
      chk("m20_busy_on_reject", bsy, 0);
      chk("m20_ready_kept", rdrop, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
